// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and width constants for the instruction fetch queue.
// Widths come from the project-wide defines so fetch and decode agree on bundle layout.
`ifndef FETCH_WIDTH
`define FETCH_WIDTH 1
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif

package inst_fetch_queue_pkg;

    localparam int unsigned FetchWidth    = `FETCH_WIDTH;
    localparam int unsigned InstAddrWidth = `INST_ADDR_WIDTH;

    typedef logic [FetchWidth-1:0][31:0] inst_bundle_t;
    typedef logic [InstAddrWidth-1:0]    inst_addr_t;

    typedef struct packed {
        inst_bundle_t inst;
        inst_addr_t   pc;
        inst_addr_t   pc_plus_4;
    } fetch_bundle_t;

    // Occupancy counter must reach Depth itself, hence one bit above the pointer width.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_storage.sv
// Bundle register array: one synchronous write port, one combinational read port.
// Asynchronous clear so nothing from before a reset can ever be read back.
module ifq_storage
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  fetch_bundle_t            wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output fetch_bundle_t            rdata_o
);

    fetch_bundle_t mem_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// In-order fetch bundle queue between fetch and decode with first-word fall-through output,
// registered skid-aware stall back to fetch, redirect flush and sticky overflow flag.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned Depth = 8,
    parameter int unsigned Skid  = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    input  logic [FetchWidth-1:0][31:0]   in_inst_i,
    input  logic [InstAddrWidth-1:0]      in_pc_i,
    input  logic [InstAddrWidth-1:0]      in_pc_plus_4_i,
    output logic                          stall_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [FetchWidth-1:0][31:0]   out_inst_o,
    output logic [InstAddrWidth-1:0]      out_pc_o,
    output logic [InstAddrWidth-1:0]      out_pc_plus_4_o,
    output logic [$clog2(Depth):0]        count_o,
    output logic                          overflow_err_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = cnt_width(Depth);
    localparam logic [CntW-1:0] FullCnt  = CntW'(Depth);
    localparam logic [CntW-1:0] StallCnt = CntW'(Depth - Skid);

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            stall_q, stall_d;
    logic            ovf_q, ovf_d;

    logic            full, empty, push, pop;
    fetch_bundle_t   wdata, rdata;

    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    assign pop   = ~empty & out_ready_i & ~flush_i;
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push  = in_valid_i & ~flush_i & (~full | pop);

    assign wdata = '{inst: in_inst_i, pc: in_pc_i, pc_plus_4: in_pc_plus_4_i};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
        // Threshold leaves Skid slots for bundles already launched by fetch.
        stall_d = ~flush_i & (count_d >= StallCnt);
        ovf_d   = ovf_q | (in_valid_i & full & ~pop & ~flush_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            ovf_q    <= ovf_d;
        end
    end

    ifq_storage #(
        .Depth (Depth)
    ) u_storage (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign out_valid_o     = ~empty;
    assign out_inst_o      = rdata.inst;
    assign out_pc_o        = rdata.pc;
    assign out_pc_plus_4_o = rdata.pc_plus_4;
    assign count_o         = count_q;
    assign stall_o         = stall_q;
    assign overflow_err_o  = ovf_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a queue-based reference model tracks accepted bundles,
// and a negedge monitor compares the DUT head, occupancy, stall and error flag against it.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int unsigned Depth = 8;
    localparam int unsigned Skid  = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    inst_bundle_t in_inst = '0;
    inst_addr_t   in_pc = '0;
    inst_addr_t   in_pc_plus_4 = '0;

    logic                   stall, out_valid, overflow_err;
    inst_bundle_t           out_inst;
    inst_addr_t             out_pc, out_pc_plus_4;
    logic [$clog2(Depth):0] count;

    int vectors = 0;
    int miscompares = 0;

    fetch_bundle_t exp_q[$];
    bit            exp_stall = 1'b0;
    bit            exp_ovf = 1'b0;

    inst_fetch_queue #(
        .Depth (Depth),
        .Skid  (Skid)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .flush_i         (flush),
        .in_valid_i      (in_valid),
        .in_inst_i       (in_inst),
        .in_pc_i         (in_pc),
        .in_pc_plus_4_i  (in_pc_plus_4),
        .stall_o         (stall),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_inst_o      (out_inst),
        .out_pc_o        (out_pc),
        .out_pc_plus_4_o (out_pc_plus_4),
        .count_o         (count),
        .overflow_err_o  (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_stall = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    // Reference model: a bundle queue updated from the behavioural rules at each clock edge.
    always @(posedge clk) begin
        bit            m_full, m_pop, m_push;
        fetch_bundle_t b;
        if (!rst_n) begin
            model_clear();
        end else if (flush) begin
            exp_q.delete();
            exp_stall = 1'b0;
        end else begin
            m_full = (exp_q.size() == Depth);
            m_pop  = (exp_q.size() != 0) && out_ready;
            m_push = in_valid && (!m_full || m_pop);
            if (in_valid && m_full && !m_pop) exp_ovf = 1'b1;
            if (m_pop) void'(exp_q.pop_front());
            if (m_push) begin
                b.inst      = in_inst;
                b.pc        = in_pc;
                b.pc_plus_4 = in_pc_plus_4;
                exp_q.push_back(b);
            end
            exp_stall = (exp_q.size() >= Depth - Skid);
        end
    end

    // Monitor: whenever the DUT presents a head, it must be the oldest outstanding bundle.
    always @(negedge clk) begin
        chk("count", count, exp_q.size());
        chk("out_valid", out_valid, exp_q.size() != 0);
        chk("stall", stall, exp_stall);
        chk("overflow_err", overflow_err, exp_ovf);
        if (out_valid && exp_q.size() != 0) begin
            chk("head_inst", out_inst, exp_q[0].inst);
            chk("head_pc", out_pc, exp_q[0].pc);
            chk("head_pc_plus_4", out_pc_plus_4, exp_q[0].pc_plus_4);
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit r, input bit f, input inst_addr_t pc);
        in_valid  = v;
        out_ready = r;
        flush     = f;
        for (int k = 0; k < FetchWidth; k++) in_inst[k] = $urandom;
        in_pc        = pc;
        in_pc_plus_4 = pc + inst_addr_t'(4);
    endtask

    task automatic random_cycles(input int n, input int v_pct, input int r_pct, input int f_pct);
        for (int c = 0; c < n; c++) begin
            drive($urandom_range(0, 99) < v_pct, $urandom_range(0, 99) < r_pct,
                  $urandom_range(0, 99) < f_pct, inst_addr_t'($urandom) & ~inst_addr_t'(3));
            cycle();
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_pc", out_pc, 0);
        chk("reset_inst", out_inst, 0);
        chk("reset_stall", stall, 0);
        chk("reset_ovf", overflow_err, 0);
        rst_n = 1'b1;

        // Fill: stall rises the cycle after the sixth push
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, inst_addr_t'(i * 4));
            cycle();
        end
        chk("fill_stall", stall, 1);
        chk("fill_count", count, 6);
        for (int i = 6; i < 8; i++) begin
            drive(1, 0, 0, inst_addr_t'(i * 4));
            cycle();
        end
        chk("fill_count_full", count, 8);
        chk("fill_ovf", overflow_err, 0);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, '0);
            chk("drain_pc", out_pc, i * 4);
            chk("drain_pc_plus_4", out_pc_plus_4, i * 4 + 4);
            chk("drain_stall", stall, (8 - i) >= 6);
            cycle();
        end
        chk("drain_empty", out_valid, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, inst_addr_t'(32'h200 + i * 4));
            cycle();
        end
        drive(1, 1, 0, inst_addr_t'(32'h220));
        cycle();
        chk("pushpop_count", count, 8);
        chk("pushpop_ovf", overflow_err, 0);
        chk("pushpop_head", out_pc, 32'h204);

        // Overflow drops the bundle and latches the error
        drive(1, 0, 0, inst_addr_t'(32'h300));
        for (int k = 0; k < FetchWidth; k++) in_inst[k] = 32'hDEADBEEF;
        cycle();
        chk("ovf_set", overflow_err, 1);
        chk("ovf_count", count, 8);
        chk("ovf_head", out_pc, 32'h204);
        drive(0, 0, 0, '0);
        cycle();
        chk("ovf_sticky", overflow_err, 1);

        // Flush overrides same-cycle push and pop
        repeat (3) begin
            drive(0, 1, 0, '0);
            cycle();
        end
        chk("preflush_count", count, 5);
        drive(1, 1, 1, inst_addr_t'(32'h400));
        cycle();
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("flush_stall", stall, 0);
        drive(1, 0, 0, inst_addr_t'(32'h100));
        cycle();
        chk("postflush_valid", out_valid, 1);
        chk("postflush_pc", out_pc, 32'h100);

        // Randomized traffic: fill-biased, then drain-biased
        random_cycles(300, 70, 30, 3);
        random_cycles(300, 40, 75, 3);

        // Asynchronous reset mid-stream with stall and overflow_err set
        drive(0, 0, 1, '0);
        cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, inst_addr_t'(32'h500 + i * 4));
            cycle();
        end
        drive(0, 0, 0, '0);
        chk("prereset_stall", stall, 1);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_count", count, 0);
        chk("async_valid", out_valid, 0);
        chk("async_stall", stall, 0);
        chk("async_ovf", overflow_err, 0);
        chk("async_pc", out_pc, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        random_cycles(200, 60, 50, 2);

        drive(0, 0, 0, '0);
        cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
